// File: rtl/brief_stream_pkg.sv
// Shared types for the two-source stream arbiter: arbiter states and source encodings.
package brief_stream_pkg;

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} arb_state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/stream_reg.sv
// Single-entry valid/ready output register carrying payload, last flag and source select.
module stream_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_sel,
  input  logic              out_ready,
  output logic              slot_free,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_sel
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;
  logic              sel_q;

  // The slot may be reloaded in the same cycle the held beat drains.
  assign slot_free = ~valid_q | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      valid_q <= load | (valid_q & ~out_ready);
      if (load) begin
        data_q <= in_data;
        last_q <= in_last;
        sel_q  <= in_sel;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_sel   = sel_q;

endmodule

// File: rtl/stream_arb2.sv
// Packet-aware round-robin arbiter for two streams; grant is held until a `last` beat is accepted.
module stream_arb2 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_sel
);

  import brief_stream_pkg::*;

  arb_state_e state_q, state_d;
  logic       rr_q, rr_d;
  logic       grant_a, grant_b;
  logic       acc_a, acc_b;
  logic       slot_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= SRC_A;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_a = a_valid & (~b_valid | (rr_q == SRC_A));
        grant_b = b_valid & ~grant_a;
      end
      LOCK_A:  grant_a = 1'b1;
      LOCK_B:  grant_b = 1'b1;
      default: ;
    endcase
    acc_a = a_valid & grant_a & slot_free;
    acc_b = b_valid & grant_b & slot_free;
    // Pointer only moves when a packet completes, favouring the other source next.
    if (acc_a) begin
      if (a_last) begin
        state_d = IDLE;
        rr_d    = SRC_B;
      end else begin
        state_d = LOCK_A;
      end
    end else if (acc_b) begin
      if (b_last) begin
        state_d = IDLE;
        rr_d    = SRC_A;
      end else begin
        state_d = LOCK_B;
      end
    end
  end

  assign a_ready = grant_a & slot_free;
  assign b_ready = grant_b & slot_free;

  stream_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (acc_a | acc_b),
    .in_data   (acc_b ? b_data : a_data),
    .in_last   (acc_b ? b_last : a_last),
    .in_sel    (acc_b ? SRC_B : SRC_A),
    .out_ready (out_ready),
    .slot_free (slot_free),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel)
  );

endmodule
